crc_engine_param: RTL
=====================

// Module: crc_engine_param
// PURPOSE
//   Parametrised, frame-aware CRC generator; successor to the fixed 8-bit/CRC-16 engine.
//   Width, polynomial, init, reflection and final XOR are all configurable.
//   Consumes DATA_W bits per cycle with sof/eof framing and a partial-last-word byte count.
//   Delivers the final CRC with a one-cycle valid strobe.
//   Sits between the packet datapath and the framer/checker. One instance per stream.
// PARAMETERS
//   CRC_W    16            CRC width in bits, 8..32
//   POLY     16'h1021      generator polynomial, normal form, implicit top bit
//   INIT     16'hFFFF      register preset at every sof
//   REFIN    0             1: bit-reverse each input byte before processing
//   REFOUT   0             1: bit-reverse the full CRC before XOR_OUT
//   XOR_OUT  16'h0000      value XORed onto the final CRC
//   DATA_W   8             input word width; multiple of 8, 8..64
//   NB_W     max(1,$clog2(DATA_W/8))   width of din_nbytes
// PORTS
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   vld         in   1       din/sof/eof/din_nbytes valid this cycle
//   sof         in   1       first word of frame, qualified by vld
//   eof         in   1       last word of frame, qualified by vld; may coincide with sof
//   din         in   DATA_W  data; first byte on din[DATA_W-1 -: 8]
//   din_nbytes  in   NB_W    on eof: valid bytes minus 1, MSB-aligned; ignored otherwise
//   crc_dout    out  CRC_W   final CRC, held until the next crc_vld
//   crc_vld     out  1       one-cycle strobe: crc_dout updated
//   busy        out  1       frame open (after sof, before eof)
//   frame_err   out  1       one-cycle strobe: framing violation
// BEHAVIOUR
//   Reset (async assert, sync release): crc_state=INIT, crc_dout=0, crc_vld=0, busy=0, frame_err=0.
//   Datapath:
//     - Unrolled combinational loop of DATA_W serial LFSR steps, MSB-first per byte after REFIN.
//     - Bytes beyond din_nbytes on the eof word are skipped (no state update for them).
//     - Start state is INIT when sof=1, otherwise crc_state.
//   Latency: CRC of a frame whose eof word arrives in cycle N appears on crc_dout with crc_vld=1 in cycle N+1.
//   Final value: crc_dout = (REFOUT ? reverse(next_state) : next_state) ^ XOR_OUT.
//     - crc_state reloads INIT.
//   No back-pressure: vld accepted every cycle; vld=0 gaps inside a frame hold state.
//   State machine (2 states):
//     IDLE: vld&sof&eof  -> single-word frame, strobe crc_vld, stay IDLE.
//           vld&sof&!eof -> accumulate, go to RUN.
//           vld&!sof     -> word dropped, frame_err=1, stay IDLE.
//     RUN:  vld&!sof&!eof -> accumulate.
//           vld&!sof&eof  -> finalise, crc_vld=1, go to IDLE.
//           vld&sof       -> frame_err=1; current frame abandoned (no crc_vld).
//                            New frame starts from INIT with this word (eof honoured -> IDLE).
//   busy = (state==RUN).
//   Reset mid-frame: frame discarded; no crc_vld or frame_err issued.
//   crc_vld and frame_err never assert together except sof&eof in RUN (restart + single-word frame).
// TESTING
//   1. Defaults, DATA_W=8, bytes "123456789" (0x31..0x39), sof on 1st, eof on 9th
//      -> crc_dout=0x29B1, crc_vld one cycle after eof.
//   2. Defaults, DATA_W=32: words 0x31323334, 0x35363738, 0x39xxxxxx with din_nbytes=0 on eof
//      -> crc_dout=0x29B1.
//   3. CRC_W=32, POLY=0x04C11DB7, INIT=XOR_OUT=0xFFFFFFFF, REFIN=REFOUT=1, "123456789" bytewise
//      -> 0xCBF43926.
//   4. Same as 1 with vld=0 gaps of 1-3 cycles between bytes -> still 0x29B1.
//      Single-byte frame (sof&eof) 0x00 with INIT=0 -> 0x0000.
//   5. In RUN, assert sof with "123456789" -> frame_err pulse, old frame dropped, new frame gives 0x29B1.
//      vld without sof in IDLE -> frame_err pulse, crc_dout unchanged.
//   6. Assert reset mid-frame after 4 bytes -> all outputs 0 immediately.
//      Next full frame after release gives 0x29B1.

Source files
------------

// File: rtl/crc_engine_param.sv
// crc_engine_param: parametrised frame-aware CRC generator with sof/eof framing and partial last word
module crc_engine_param #(
  parameter int              CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021,
  parameter logic [CRC_W-1:0] INIT   = 16'hFFFF,
  parameter bit              REFIN   = 1'b0,
  parameter bit              REFOUT  = 1'b0,
  parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
  parameter int              DATA_W  = 8,
  parameter int              NB_W    = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld,
  input  logic              sof,
  input  logic              eof,
  input  logic [DATA_W-1:0] din,
  input  logic [NB_W-1:0]   din_nbytes,
  output logic [CRC_W-1:0]  crc_dout,
  output logic              crc_vld,
  output logic              busy,
  output logic              frame_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [CRC_W-1:0] crc_state, crc_nxt, crc_fin;
  logic accept, fin;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] revc(input logic [CRC_W-1:0] x);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = x[CRC_W-1-i];
    return r;
  endfunction

  // Bytes past din_nbytes on the eof word leave the register untouched.
  always_comb begin : datapath
    logic [CRC_W-1:0] c;
    logic [7:0] d;
    c = sof ? INIT : crc_state;
    d = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      d = REFIN ? rev8(din[DATA_W-1-8*b -: 8]) : din[DATA_W-1-8*b -: 8];
      if (!eof || b <= int'(din_nbytes))
        for (int i = 7; i >= 0; i--) c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ d[i]) ? POLY : '0);
    end
    crc_nxt = c;
  end

  always_comb begin
    accept    = vld && (sof || state == RUN);
    fin       = accept && eof;
    state_nxt = fin ? IDLE : accept ? RUN : state;
    crc_fin   = (REFOUT ? revc(crc_nxt) : crc_nxt) ^ XOR_OUT;
    busy      = state == RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      crc_state <= INIT;
      crc_dout  <= '0;
      crc_vld   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      crc_state <= fin ? INIT : accept ? crc_nxt : crc_state;
      crc_vld   <= fin;
      if (fin) crc_dout <= crc_fin;
      frame_err <= vld && (sof ? busy : !busy);
    end
  end
endmodule
